// File: rtl/sdram_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_read_arbiter_if
// Bundles every bus signal around the SDRAM read arbiter:
//   a_*  : master A (command reader, read only)
//   b_*  : master B (rasterizer / frame buffer, read and write)
//   m_*  : the shared 64-bit SDRAM Avalon-MM port (29-bit word address)
//   err_orphan : sticky flag, read data arrived with no outstanding tag
// Modport slave is the arbiter's view; modport master is the view of whatever
// surrounds it (both masters plus the SDRAM port).
// ---------------------------------------------------------------------------
interface sdram_read_arbiter_if;
    logic [28:0] a_address;
    logic [7:0]  a_burstcount;
    logic        a_read;
    logic        a_waitrequest;
    logic [63:0] a_readdata;
    logic        a_readdatavalid;

    logic [28:0] b_address;
    logic [7:0]  b_burstcount;
    logic        b_read;
    logic        b_write;
    logic [63:0] b_writedata;
    logic [7:0]  b_byteenable;
    logic        b_waitrequest;
    logic [63:0] b_readdata;
    logic        b_readdatavalid;

    logic [28:0] m_address;
    logic [7:0]  m_burstcount;
    logic        m_read;
    logic        m_write;
    logic [63:0] m_writedata;
    logic [7:0]  m_byteenable;
    logic        m_waitrequest;
    logic [63:0] m_readdata;
    logic        m_readdatavalid;

    logic        err_orphan;

    modport slave (
        input  a_address, a_burstcount, a_read,
        output a_waitrequest, a_readdata, a_readdatavalid,
        input  b_address, b_burstcount, b_read, b_write, b_writedata, b_byteenable,
        output b_waitrequest, b_readdata, b_readdatavalid,
        output m_address, m_burstcount, m_read, m_write, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        output err_orphan
    );

    modport master (
        output a_address, a_burstcount, a_read,
        input  a_waitrequest, a_readdata, a_readdatavalid,
        output b_address, b_burstcount, b_read, b_write, b_writedata, b_byteenable,
        input  b_waitrequest, b_readdata, b_readdatavalid,
        input  m_address, m_burstcount, m_read, m_write, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid,
        input  err_orphan
    );
endinterface

// File: rtl/sdram_read_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_read_arbiter
// Shares one SDRAM Avalon-MM port between master A (reads) and master B
// (reads and writes). Commands pass combinationally from the granted master;
// grant rotates per accepted command, and a B write burst keeps the grant
// until its last beat. Each accepted read pushes {owner, beats} into a tag
// FIFO so returning data can be steered to the right master in order.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus            : sdram_read_arbiter_if.slave (A, B, SDRAM and err_orphan)
// ---------------------------------------------------------------------------
module sdram_read_arbiter #(
    parameter int TAG_DEPTH      = 16,
    parameter int TAG_DEPTH_LOG2 = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sdram_read_arbiter_if.slave  bus
);

    localparam logic [TAG_DEPTH_LOG2:0] FULL_COUNT = (TAG_DEPTH_LOG2 + 1)'(TAG_DEPTH);
    localparam logic [TAG_DEPTH_LOG2:0] ZERO_COUNT = {(TAG_DEPTH_LOG2 + 1){1'b0}};

    logic                      grant_r;
    logic                      grant_next_s;
    logic [7:0]                wr_beats_left_r;
    logic [7:0]                wr_beats_next_s;
    logic [TAG_DEPTH_LOG2-1:0] rd_ptr_r;
    logic [TAG_DEPTH_LOG2-1:0] wr_ptr_r;
    logic [TAG_DEPTH_LOG2:0]   count_r;
    logic                      err_orphan_r;
    logic                      owner_mem_r [TAG_DEPTH];
    logic [7:0]                beats_mem_r [TAG_DEPTH];

    logic       tag_full_s;
    logic       tag_empty_s;
    logic       a_req_s;
    logic       b_req_s;
    logic       m_read_s;
    logic       m_write_s;
    logic       read_accept_s;
    logic       write_accept_s;
    logic       accept_s;
    logic       beat_s;
    logic       pop_s;
    logic       head_owner_s;
    logic [7:0] head_beats_s;
    logic [7:0] push_beats_s;

    assign tag_full_s   = (count_r == FULL_COUNT);
    assign tag_empty_s  = (count_r == ZERO_COUNT);
    assign a_req_s      = bus.a_read;
    assign b_req_s      = bus.b_read | bus.b_write;
    assign head_owner_s = owner_mem_r[rd_ptr_r];
    assign head_beats_s = beats_mem_r[rd_ptr_r];

    // Command mux from the granted master; reads are held off while the tag FIFO is full.
    always_comb begin
        m_read_s          = 1'b0;
        m_write_s         = 1'b0;
        bus.a_waitrequest = 1'b1;
        bus.b_waitrequest = 1'b1;
        if (reset_n == 1'b0) begin
            m_read_s  = 1'b0;
            m_write_s = 1'b0;
        end else if (grant_r == 1'b1) begin
            // A master issuing a write never issues a read in the same cycle.
            m_write_s         = bus.b_write;
            m_read_s          = bus.b_read & ~bus.b_write & ~tag_full_s;
            bus.b_waitrequest = bus.m_waitrequest | (bus.b_read & ~bus.b_write & tag_full_s);
        end else begin
            m_read_s          = bus.a_read & ~tag_full_s;
            bus.a_waitrequest = bus.m_waitrequest | (bus.a_read & tag_full_s);
        end
        bus.m_read       = m_read_s;
        bus.m_write      = m_write_s;
        bus.m_address    = grant_r ? bus.b_address    : bus.a_address;
        bus.m_burstcount = grant_r ? bus.b_burstcount : bus.a_burstcount;
        bus.m_writedata  = bus.b_writedata;
        bus.m_byteenable = grant_r ? bus.b_byteenable : 8'hFF;
    end

    assign read_accept_s  = m_read_s  & ~bus.m_waitrequest;
    assign write_accept_s = m_write_s & ~bus.m_waitrequest;
    assign accept_s       = read_accept_s | write_accept_s;
    assign push_beats_s   = (bus.m_burstcount == 8'd0) ? 8'd1 : bus.m_burstcount;

    // Write-burst beat tracking and next grant; a stalled request is never preempted.
    always_comb begin
        wr_beats_next_s = wr_beats_left_r;
        grant_next_s    = grant_r;
        if (write_accept_s == 1'b1) begin
            if (wr_beats_left_r == 8'd0) begin
                wr_beats_next_s = (bus.m_burstcount == 8'd0) ? 8'd0 : (bus.m_burstcount - 8'd1);
            end else begin
                wr_beats_next_s = wr_beats_left_r - 8'd1;
            end
        end else begin
            wr_beats_next_s = wr_beats_left_r;
        end
        if (wr_beats_next_s != 8'd0) begin
            grant_next_s = grant_r;
        end else if (accept_s || !(grant_r ? b_req_s : a_req_s)) begin
            grant_next_s = (grant_r ? a_req_s : b_req_s) ? ~grant_r : grant_r;
        end else begin
            grant_next_s = grant_r;
        end
    end

    // Response steering: data fans out, the strobe goes only to the head tag's owner.
    always_comb begin
        beat_s              = bus.m_readdatavalid & reset_n & ~tag_empty_s;
        pop_s               = beat_s & (head_beats_s <= 8'd1);
        bus.a_readdata      = bus.m_readdata;
        bus.b_readdata      = bus.m_readdata;
        bus.a_readdatavalid = beat_s & ~head_owner_s;
        bus.b_readdatavalid = beat_s &  head_owner_s;
        bus.err_orphan      = err_orphan_r;
    end

    // Grant, write lock and orphan-flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_r         <= 1'b0;
            wr_beats_left_r <= 8'd0;
            err_orphan_r    <= 1'b0;
        end else begin
            grant_r         <= grant_next_s;
            wr_beats_left_r <= wr_beats_next_s;
            err_orphan_r    <= err_orphan_r | (bus.m_readdatavalid & tag_empty_s);
        end
    end

    // Tag FIFO: pointers, occupancy and per-entry {owner, beats remaining}.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r <= {TAG_DEPTH_LOG2{1'b0}};
            wr_ptr_r <= {TAG_DEPTH_LOG2{1'b0}};
            count_r  <= ZERO_COUNT;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                owner_mem_r[i] <= 1'b0;
                beats_mem_r[i] <= 8'd0;
            end
        end else begin
            // Push and head update never hit the same slot: push needs !full, a beat needs !empty.
            if (read_accept_s) begin
                owner_mem_r[wr_ptr_r] <= grant_r;
                beats_mem_r[wr_ptr_r] <= push_beats_s;
                wr_ptr_r              <= wr_ptr_r + {{(TAG_DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            if (beat_s && !pop_s) begin
                beats_mem_r[rd_ptr_r] <= head_beats_s - 8'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(TAG_DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            case ({read_accept_s, pop_s})
                2'b10:   count_r <= count_r + {{TAG_DEPTH_LOG2{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{TAG_DEPTH_LOG2{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_read_arbiter.sv
module tb_sdram_read_arbiter;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;
    logic exp_owner_q [$];

    sdram_read_arbiter_if bus ();

    sdram_read_arbiter #(.TAG_DEPTH(16), .TAG_DEPTH_LOG2(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        bus.a_address       = 29'h0;
        bus.a_burstcount    = 8'd1;
        bus.a_read          = 1'b0;
        bus.b_address       = 29'h0;
        bus.b_burstcount    = 8'd1;
        bus.b_read          = 1'b0;
        bus.b_write         = 1'b0;
        bus.b_writedata     = 64'h0;
        bus.b_byteenable    = 8'hFF;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdata      = 64'h0;
        bus.m_readdatavalid = 1'b0;
    endtask

    task automatic test_reset;
        logic exp_owner;
        idle_inputs();
        reset_n = 1'b0;
        bus.a_read = 1'b1;
        bus.b_write = 1'b1;
        bus.m_readdatavalid = 1'b1;
        #2;
        checks++;
        if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0 ||
            bus.a_readdatavalid !== 1'b0 || bus.b_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: m_read=%b m_write=%b a_rdv=%b b_rdv=%b, expected all 0",
                     bus.m_read, bus.m_write, bus.a_readdatavalid, bus.b_readdatavalid);
        end
        idle_inputs();
        cyc();
        cyc();
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.err_orphan !== 1'b0 || bus.a_waitrequest !== 1'b0 || bus.b_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: err_orphan=%b a_wait=%b b_wait=%b, expected 0 0 1",
                     bus.err_orphan, bus.a_waitrequest, bus.b_waitrequest);
        end
        cyc();
        exp_owner = 1'b0;
    endtask

    task automatic test_single_read;
        logic exp_owner;
        bus.a_address = 29'h10;
        bus.a_burstcount = 8'd1;
        bus.a_read = 1'b1;
        #1;
        checks++;
        if (bus.m_read !== 1'b1 || bus.m_address !== 29'h10 || bus.a_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL single_cmd: m_read=%b m_address=%h a_wait=%b, expected 1 10 0",
                     bus.m_read, bus.m_address, bus.a_waitrequest);
        end
        exp_owner_q.push_back(1'b0);
        cyc();
        bus.a_read = 1'b0;
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata = 64'hDEAD;
        #1;
        exp_owner = exp_owner_q.pop_front();
        checks++;
        if (bus.a_readdatavalid !== ~exp_owner || bus.b_readdatavalid !== exp_owner ||
            bus.a_readdata !== 64'hDEAD) begin
            errors++;
            $display("FAIL single_resp: a_rdv=%b b_rdv=%b a_data=%h, expected 1 0 dead",
                     bus.a_readdatavalid, bus.b_readdatavalid, bus.a_readdata);
        end
        cyc();
        bus.m_readdatavalid = 1'b0;
    endtask

    task automatic test_round_robin;
        logic        exp_owner;
        logic [28:0] exp_addr;
        logic [63:0] d;
        bus.a_address = 29'h100;
        bus.b_address = 29'h200;
        bus.a_burstcount = 8'd1;
        bus.b_burstcount = 8'd1;
        bus.a_read = 1'b1;
        bus.b_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_owner = (i % 2 == 1);
            exp_addr = exp_owner ? 29'h200 : 29'h100;
            #1;
            checks++;
            if (bus.m_read !== 1'b1 || bus.m_address !== exp_addr) begin
                errors++;
                $display("FAIL rr_order[%0d]: m_read=%b m_address=%h, expected 1 %h",
                         i, bus.m_read, bus.m_address, exp_addr);
            end
            exp_owner_q.push_back(exp_owner);
            cyc();
        end
        bus.a_read = 1'b0;
        bus.b_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = 64'(i + 1);
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata = d;
            #1;
            exp_owner = exp_owner_q.pop_front();
            checks++;
            if (bus.a_readdatavalid !== ~exp_owner || bus.b_readdatavalid !== exp_owner ||
                bus.a_readdata !== d || bus.b_readdata !== d) begin
                errors++;
                $display("FAIL rr_resp[%0d]: a_rdv=%b b_rdv=%b data=%h, expected owner=%0d data=%h",
                         i, bus.a_readdatavalid, bus.b_readdatavalid, bus.a_readdata, exp_owner, d);
            end
            cyc();
        end
        bus.m_readdatavalid = 1'b0;
    endtask

    task automatic test_write_lock;
        logic        exp_owner;
        logic [63:0] wd;
        bus.b_address = 29'h300;
        bus.b_burstcount = 8'd4;
        bus.b_write = 1'b1;
        bus.b_writedata = 64'hB000;
        #1;
        checks++;
        if (bus.b_waitrequest !== 1'b1 || bus.m_write !== 1'b0) begin
            errors++;
            $display("FAIL wr_ungranted: b_wait=%b m_write=%b, expected 1 0", bus.b_waitrequest, bus.m_write);
        end
        cyc();
        bus.a_address = 29'h400;
        bus.a_burstcount = 8'd1;
        bus.a_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wd = 64'hB000 + 64'(k);
            bus.b_writedata = wd;
            bus.m_waitrequest = (k == 2 || k == 3);
            #1;
            checks++;
            if (bus.m_write !== 1'b1 || bus.a_waitrequest !== 1'b1 ||
                bus.b_waitrequest !== bus.m_waitrequest || bus.m_writedata !== wd) begin
                errors++;
                $display("FAIL wr_lock[%0d]: m_write=%b a_wait=%b b_wait=%b wdata=%h, expected 1 1 %b %h",
                         k, bus.m_write, bus.a_waitrequest, bus.b_waitrequest, bus.m_writedata,
                         bus.m_waitrequest, wd);
            end
            cyc();
        end
        bus.b_write = 1'b0;
        bus.m_waitrequest = 1'b0;
        #1;
        checks++;
        if (bus.a_waitrequest !== 1'b0 || bus.m_read !== 1'b1 || bus.m_address !== 29'h400) begin
            errors++;
            $display("FAIL wr_release: a_wait=%b m_read=%b m_address=%h, expected 0 1 400",
                     bus.a_waitrequest, bus.m_read, bus.m_address);
        end
        exp_owner_q.push_back(1'b0);
        cyc();
        bus.a_read = 1'b0;
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata = 64'h55;
        #1;
        exp_owner = exp_owner_q.pop_front();
        checks++;
        if (bus.a_readdatavalid !== ~exp_owner || bus.b_readdatavalid !== exp_owner) begin
            errors++;
            $display("FAIL wr_after_resp: a_rdv=%b b_rdv=%b, expected owner=%0d",
                     bus.a_readdatavalid, bus.b_readdatavalid, exp_owner);
        end
        cyc();
        bus.m_readdatavalid = 1'b0;
    endtask

    task automatic test_tag_full;
        logic        exp_owner;
        logic [63:0] d;
        bus.a_burstcount = 8'd1;
        bus.a_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.a_address = 29'h1000 + 29'(i);
            #1;
            checks++;
            if (bus.m_read !== 1'b1 || bus.a_waitrequest !== 1'b0) begin
                errors++;
                $display("FAIL full_fill[%0d]: m_read=%b a_wait=%b, expected 1 0", i, bus.m_read, bus.a_waitrequest);
            end
            exp_owner_q.push_back(1'b0);
            cyc();
        end
        bus.a_address = 29'h2000;
        #1;
        checks++;
        if (bus.a_waitrequest !== 1'b1 || bus.m_read !== 1'b0) begin
            errors++;
            $display("FAIL full_block: a_wait=%b m_read=%b, expected 1 0", bus.a_waitrequest, bus.m_read);
        end
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata = 64'h100;
        #1;
        exp_owner = exp_owner_q.pop_front();
        checks++;
        if (bus.a_readdatavalid !== ~exp_owner || bus.b_readdatavalid !== exp_owner) begin
            errors++;
            $display("FAIL full_resp: a_rdv=%b b_rdv=%b, expected owner=%0d",
                     bus.a_readdatavalid, bus.b_readdatavalid, exp_owner);
        end
        cyc();
        bus.m_readdatavalid = 1'b0;
        #1;
        checks++;
        if (bus.a_waitrequest !== 1'b0 || bus.m_read !== 1'b1) begin
            errors++;
            $display("FAIL full_free: a_wait=%b m_read=%b, expected 0 1", bus.a_waitrequest, bus.m_read);
        end
        exp_owner_q.push_back(1'b0);
        cyc();
        bus.a_read = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d = 64'h200 + 64'(i);
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata = d;
            #1;
            exp_owner = exp_owner_q.pop_front();
            checks++;
            if (bus.a_readdatavalid !== ~exp_owner || bus.b_readdatavalid !== exp_owner ||
                bus.a_readdata !== d) begin
                errors++;
                $display("FAIL full_drain[%0d]: a_rdv=%b b_rdv=%b data=%h, expected owner=%0d data=%h",
                         i, bus.a_readdatavalid, bus.b_readdatavalid, bus.a_readdata, exp_owner, d);
            end
            cyc();
        end
        bus.m_readdatavalid = 1'b0;
    endtask

    task automatic test_interleave_orphan;
        logic exp_owner;
        int   a_cnt;
        int   b_cnt;
        a_cnt = 0;
        b_cnt = 0;
        bus.b_address = 29'h500;
        bus.b_burstcount = 8'd3;
        bus.b_read = 1'b1;
        #1;
        checks++;
        if (bus.b_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL il_b_wait: b_wait=%b, expected 1", bus.b_waitrequest);
        end
        cyc();
        bus.a_address = 29'h600;
        bus.a_burstcount = 8'd1;
        bus.a_read = 1'b1;
        #1;
        checks++;
        if (bus.m_read !== 1'b1 || bus.m_address !== 29'h500 || bus.m_burstcount !== 8'd3) begin
            errors++;
            $display("FAIL il_b_cmd: m_read=%b addr=%h burst=%0d, expected 1 500 3",
                     bus.m_read, bus.m_address, bus.m_burstcount);
        end
        for (int i = 0; i < 3; i++) exp_owner_q.push_back(1'b1);
        cyc();
        bus.b_read = 1'b0;
        #1;
        checks++;
        if (bus.m_read !== 1'b1 || bus.m_address !== 29'h600 || bus.m_burstcount !== 8'd1) begin
            errors++;
            $display("FAIL il_a_cmd: m_read=%b addr=%h burst=%0d, expected 1 600 1",
                     bus.m_read, bus.m_address, bus.m_burstcount);
        end
        exp_owner_q.push_back(1'b0);
        cyc();
        bus.a_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata = 64'hC00 + 64'(i);
            #1;
            exp_owner = exp_owner_q.pop_front();
            checks++;
            if (bus.a_readdatavalid !== ~exp_owner || bus.b_readdatavalid !== exp_owner) begin
                errors++;
                $display("FAIL il_resp[%0d]: a_rdv=%b b_rdv=%b, expected owner=%0d",
                         i, bus.a_readdatavalid, bus.b_readdatavalid, exp_owner);
            end
            if (bus.a_readdatavalid === 1'b1) a_cnt++;
            if (bus.b_readdatavalid === 1'b1) b_cnt++;
            cyc();
        end
        checks++;
        if (a_cnt != 1 || b_cnt != 3) begin
            errors++;
            $display("FAIL il_counts: a_rdv cycles=%0d b_rdv cycles=%0d, expected 1 3", a_cnt, b_cnt);
        end
        checks++;
        if (bus.err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL orphan_pre: err_orphan=%b, expected 0", bus.err_orphan);
        end
        bus.m_readdata = 64'hBAD;
        #1;
        checks++;
        if (bus.a_readdatavalid !== 1'b0 || bus.b_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL orphan_strobe: a_rdv=%b b_rdv=%b, expected 0 0",
                     bus.a_readdatavalid, bus.b_readdatavalid);
        end
        cyc();
        bus.m_readdatavalid = 1'b0;
        #1;
        checks++;
        if (bus.err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_set: err_orphan=%b, expected 1", bus.err_orphan);
        end
        cyc();
        cyc();
        checks++;
        if (bus.err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_sticky: err_orphan=%b, expected 1", bus.err_orphan);
        end
    endtask

    task automatic test_reset_mid_write;
        logic exp_owner;
        bus.b_address = 29'h700;
        bus.b_burstcount = 8'd4;
        bus.b_write = 1'b1;
        cyc();
        cyc();
        #1;
        checks++;
        if (bus.m_write !== 1'b1) begin
            errors++;
            $display("FAIL rmw_writing: m_write=%b, expected 1", bus.m_write);
        end
        cyc();
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.m_write !== 1'b0 || bus.err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL rmw_reset: m_write=%b err_orphan=%b, expected 0 0", bus.m_write, bus.err_orphan);
        end
        cyc();
        bus.b_write = 1'b0;
        cyc();
        reset_n = 1'b1;
        bus.a_address = 29'h800;
        bus.a_burstcount = 8'd1;
        bus.a_read = 1'b1;
        #1;
        checks++;
        if (bus.a_waitrequest !== 1'b0 || bus.m_read !== 1'b1 || bus.m_address !== 29'h800) begin
            errors++;
            $display("FAIL rmw_a_read: a_wait=%b m_read=%b addr=%h, expected 0 1 800",
                     bus.a_waitrequest, bus.m_read, bus.m_address);
        end
        exp_owner_q.push_back(1'b0);
        cyc();
        bus.a_read = 1'b0;
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata = 64'h77;
        #1;
        exp_owner = exp_owner_q.pop_front();
        checks++;
        if (bus.a_readdatavalid !== ~exp_owner || bus.b_readdatavalid !== exp_owner ||
            bus.err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL rmw_resp: a_rdv=%b b_rdv=%b err_orphan=%b, expected owner=%0d no orphan",
                     bus.a_readdatavalid, bus.b_readdatavalid, bus.err_orphan, exp_owner);
        end
        cyc();
        bus.m_readdatavalid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_lock();
        test_tag_full();
        test_interleave_orphan();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_read_arbiter.md
Name: sdram_read_arbiter

Overview:
- Two-master arbiter sharing the single 64-bit SDRAM Avalon-MM port (29-bit word address).
- Master A is the command reader (read only); master B is the rasterizer/frame-buffer path (read and write).
- Fair per-command round robin; write bursts are locked until their last beat.
- Read responses are routed back in order using a tag FIFO of (owner, beats-remaining).

Parameters:
- TAG_DEPTH, 16, max outstanding read bursts tracked.
- TAG_DEPTH_LOG2, 4, log2(TAG_DEPTH).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- a_address  in  29  master A word address
- a_burstcount  in  8  master A burst length
- a_read  in  1  master A read request
- a_waitrequest  out  1  master A stall
- a_readdata  out  64  master A read data
- a_readdatavalid  out  1  master A data strobe
- b_address  in  29  master B word address
- b_burstcount  in  8  master B burst length
- b_read  in  1  master B read request
- b_write  in  1  master B write request
- b_writedata  in  64  master B write data
- b_byteenable  in  8  master B byte enables
- b_waitrequest  out  1  master B stall
- b_readdata  out  64  master B read data
- b_readdatavalid  out  1  master B data strobe
- m_address, m_burstcount, m_read, m_write, m_writedata, m_byteenable  out  29/8/1/1/64/8  to SDRAM port
- m_waitrequest  in  1  SDRAM stall
- m_readdata  in  64  SDRAM read data
- m_readdatavalid  in  1  SDRAM data strobe
- err_orphan  out  1  sticky: readdatavalid arrived with tag FIFO empty

Behaviour:
- State
  - grant (0=A, 1=B)
  - tag FIFO of {owner, beats[7:0]}, head beat counter
  - wr_beats_left[7:0] for the locked B write burst
  - err_orphan
- Reset: grant=A, tag FIFO empty, wr_beats_left=0, err_orphan=0. While reset_n=0, m_read=m_write=0 and both readdatavalid=0.
- Command path is combinational from the granted master to m_*, with zero added latency. The ungranted master sees waitrequest=1.
- tag_full blocks reads:
  - Granted read: m_read = req & !tag_full.
  - Granted master waitrequest = m_waitrequest | (read & tag_full).
- accept = (m_read|m_write) & !m_waitrequest.
- Read accept pushes {grant, burstcount}. burstcount 0 is treated as 1 on push.
- Write accept:
  - wr_beats_left=0: load burstcount-1 (0 treated as 1).
  - Otherwise: decrement wr_beats_left.
  - Lock holds while wr_beats_left!=0 after the update.
  - During lock, m_burstcount/m_address still forward from B; the slave ignores them per Avalon.
- Grant update at each clock edge, unless locked:
  - If accept this cycle, or the granted master requests nothing: grant goes to the other master if it requests, else stays.
  - A stalled (waitrequest) request is never preempted.
- Response routing:
  - m_readdata fans out to both masters.
  - On m_readdatavalid with the tag FIFO non-empty: the owner's readdatavalid=1 that same cycle (combinational); decrement head beats; pop when beats reaches 1.
  - On m_readdatavalid with the tag FIFO empty: both readdatavalid=0; set err_orphan.
- Simultaneous push and pop in one cycle is legal and leaves occupancy unchanged. The final response beat frees its slot one cycle later; tag_full is computed from registered occupancy.
- Master A never writes. B byteenable/writedata are ignored on reads.

Test Plan:
- Reset, then A reads addr 0x10 burst 1, m_waitrequest=0 → m_read=1 same cycle; one cycle later m_readdatavalid with data 0xDEAD → a_readdatavalid=1, a_readdata=0xDEAD, b_readdatavalid=0.
- A and B both hold reads every cycle → accepted commands alternate A,B,A,B; responses of 0x1,0x2,0x3,0x4 route to A,B,A,B in order.
- B writes burst 4 while A requests → A waits until the 4th B beat is accepted; a_waitrequest=0 the cycle after; m_waitrequest held 2 cycles mid-burst → grant stays B.
- Hold m_readdatavalid=0 and issue 16 A reads → 17th read sees a_waitrequest=1, m_read=0; one response beat → next cycle the read is accepted.
- Read burst 3 from B interleaved with A burst 1: response beats 3+1 → b_readdatavalid exactly 3 cycles, then a_readdatavalid 1; an extra beat with FIFO empty → err_orphan=1 sticky until reset.
- Assert reset_n=0 mid B write burst → m_write=0 immediately; after release, grant=A, no lock, A read accepted at once.
